// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LDDATA = 3'd2,
    MERGE  = 3'd3,
    WR     = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reject illegal size, misalignment or an address outside [lo, hi].
  function automatic logic access_error(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic bad_size;
    logic misaligned;
    logic out_of_range;
    if (we)
      bad_size = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else
      bad_size = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                   f3 == F3_BU || f3 == F3_HU);
    misaligned   = (f3[1:0] == 2'b01 && addr[0]) ||
                   (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    out_of_range = (addr < lo) || (addr > hi);
    return bad_size || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_mem_lane_align.sv
// Little-endian lane extraction (loads) and lane merge (sub-word stores).
module lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    if (funct3[1:0] == 2'b00)
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
    else if (funct3[1:0] == 2'b01)
      merged[{offset[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit driving a word-wide synchronous RAM; sub-word stores are
// done as read-modify-write. All RAM-side outputs are registered.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int          DWIDTH  = 32,
  parameter logic [31:0] ADDR_LO = 32'h100,
  parameter logic [31:0] ADDR_HI = 32'h1FF
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              ramR,
  output logic              ramW,
  output logic [31:0]       ramAddr,
  output logic [DWIDTH-1:0] ramDataW,
  input  logic [DWIDTH-1:0] ramDataR
);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_bad = access_error(we, funct3, addr, ADDR_LO, ADDR_HI);

  lane_align u_lane_align (
    .word      (ramDataR),
    .offset    (off_q),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Valid/ready: a request is taken on any edge where req=1 and busy=0;
  // done is the single-cycle completion pulse, err qualifies it.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      ramR     <= 1'b0;
      ramW     <= 1'b0;
      ramAddr  <= '0;
      ramDataW <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      ramR <= 1'b0;
      ramW <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (req_bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              off_q   <= addr[1:0];
              f3_q    <= funct3;
              we_q    <= we;
              wdata_q <= wdata[15:0];
              ramAddr <= {2'b00, addr[31:2]};
              busy    <= 1'b1;
              // Full-word stores skip the read; everything else reads first.
              if (we && funct3 == F3_W) begin
                ramW     <= 1'b1;
                ramDataW <= wdata;
                state    <= WR;
              end else begin
                ramR  <= 1'b1;
                state <= RD;
              end
            end
          end
        end
        RD: state <= we_q ? MERGE : LDDATA;
        LDDATA: begin
          rdata <= load_data;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        MERGE: begin
          ramDataW <= merged;
          ramW     <= 1'b1;
          state    <= WR;
        end
        WR: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem with a behavioural one-cycle-latency word RAM.
module tb_lsu_mem;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, ramR, ramW;
  logic [31:0] rdata, ramAddr, ramDataW;
  logic [31:0] ramDataR;

  logic [31:0] mem [0:127];
  logic [31:0] exp_q[$];

  int r_rise = 0;
  int w_rise = 0;
  int done_rise = 0;
  logic [31:0] last_wr = 32'h0;

  int n_tests = 0;
  int n_fail = 0;

  lsu_mem dut (
    .clock    (clock),
    .nreset   (nreset),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .ramR     (ramR),
    .ramW     (ramW),
    .ramAddr  (ramAddr),
    .ramDataW (ramDataW),
    .ramDataR (ramDataR)
  );

  // clock / RAM model / activity monitors
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ramR) ramDataR <= mem[ramAddr[6:0]];
    if (ramW) mem[ramAddr[6:0]] <= ramDataW;
  end

  always @(posedge ramR) r_rise++;
  always @(posedge ramW) w_rise++;
  always @(posedge done) done_rise++;
  always @(negedge clock) if (ramW) last_wr = ramDataW;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request, hold-off until done (bounded), then check everything.
  task automatic expect_op(input string tag, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rd, input int exp_r, input int exp_w);
    int lat;
    int r0;
    int w0;
    @(negedge clock);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    r0 = r_rise; w0 = w_rise;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(busy), exp_err ? 32'd0 : 32'd1);
    while (!done && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_ramR"}, r_rise - r0, exp_r);
    check({tag, "_ramW"}, w_rise - w0, exp_w);
    @(negedge clock);
    check({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  // req held high with alternating SW/LW; each accepted on the done edge.
  task automatic back_to_back();
    logic        ow [4];
    logic [31:0] oa [4];
    logic [31:0] od [4];
    int          done_at [4];
    int          idx;
    int          r0;
    int          w0;
    int          d0;
    ow = '{1'b1, 1'b0, 1'b1, 1'b0};
    oa = '{32'h180, 32'h180, 32'h184, 32'h184};
    od = '{32'h0F0F_1234, 32'h0, 32'hA5A5_5A5A, 32'h0};
    done_at = '{2, 5, 7, 10};
    @(negedge clock);
    r0 = r_rise; w0 = w_rise; d0 = done_rise;
    req = 1'b1; we = ow[0]; funct3 = 3'b010; addr = oa[0]; wdata = od[0];
    idx = 0;
    for (int c = 1; c <= 14 && idx < 4; c++) begin
      @(negedge clock);
      if (done) begin
        check("b2b_cycle", c, done_at[idx]);
        check("b2b_err", 32'(err), 32'd0);
        if (!ow[idx]) check("b2b_rdata", rdata, exp_q.pop_front());
        idx++;
        if (idx < 4) begin
          we = ow[idx]; addr = oa[idx]; wdata = od[idx];
          if (!ow[idx]) exp_q.push_back(od[idx-1]);
        end else begin
          req = 1'b0;
        end
      end
    end
    check("b2b_count", idx, 4);
    check("b2b_ramR", r_rise - r0, 2);
    check("b2b_ramW", w_rise - w0, 2);
    check("b2b_dones", done_rise - d0, 4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ramR"}, 32'(ramR), 32'd0);
    check({tag, "_ramW"}, 32'(ramW), 32'd0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_ramAddr"}, ramAddr, 32'h0);
    check({tag, "_ramDataW"}, ramDataW, 32'h0);
  endtask

  initial begin
    int w0;
    int d0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[64] = 32'h80F1_7F22;
    mem[65] = 32'hCAFE_0104;

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    nreset = 1'b1;

    // loads of the preloaded word
    expect_op("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 3, 1'b0, 32'h0000_007F, 1, 0);
    expect_op("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 3, 1'b0, 32'hFFFF_FF80, 1, 0);
    expect_op("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 3, 1'b0, 32'h0000_0080, 1, 0);

    // SW then SH read-modify-write
    expect_op("sw_100", 1'b1, 3'b010, 32'h100, 32'h1122_3344, 2, 1'b0, 32'h0000_0080, 0, 1);
    check("sw_100_data", last_wr, 32'h1122_3344);
    expect_op("sh_102", 1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0080, 1, 1);
    check("sh_102_data", last_wr, 32'hBEEF_3344);
    expect_op("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b0, 32'hBEEF_3344, 1, 0);
    expect_op("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 3, 1'b0, 32'h0000_BEEF, 1, 0);
    expect_op("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 3, 1'b0, 32'hFFFF_BEEF, 1, 0);
    expect_op("lh_100",  1'b0, 3'b001, 32'h100, 32'h0, 3, 1'b0, 32'h0000_3344, 1, 0);

    // SB into lane 1
    expect_op("sb_101", 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 4, 1'b0, 32'h0000_3344, 1, 1);
    check("sb_101_data", last_wr, 32'hBEEF_A544);
    expect_op("lw_100b", 1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b0, 32'hBEEF_A544, 1, 0);

    // top-of-range round trip
    expect_op("sw_1fc", 1'b1, 3'b010, 32'h1FC, 32'h1234_5678, 2, 1'b0, 32'hBEEF_A544, 0, 1);
    expect_op("lw_1fc", 1'b0, 3'b010, 32'h1FC, 32'h0, 3, 1'b0, 32'h1234_5678, 1, 0);

    // rejected requests: no RAM traffic, rdata held
    expect_op("lw_200",   1'b0, 3'b010, 32'h200, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("lh_101",   1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("st_f3_011", 1'b1, 3'b011, 32'h100, 32'hFFFF_FFFF, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("lw_0fc",   1'b0, 3'b010, 32'h0FC, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("ld_f3_110", 1'b0, 3'b110, 32'h100, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("sw_1fe",   1'b1, 3'b010, 32'h1FE, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 0);
    expect_op("sb_1ff",   1'b1, 3'b000, 32'h1FF, 32'h0000_0077, 4, 1'b0, 32'h1234_5678, 1, 1);
    check("sb_1ff_data", last_wr, 32'h7734_5678);

    back_to_back();

    // reset asserted during MERGE of an SB
    @(negedge clock);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h104; wdata = 32'h0000_005A;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    w0 = w_rise; d0 = done_rise;
    nreset = 1'b0;
    #1;
    check_all_zero("rst_merge");
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    check("rst_no_ramW", w_rise - w0, 0);
    check("rst_no_done", done_rise - d0, 0);
    expect_op("lw_104", 1'b0, 3'b010, 32'h104, 32'h0, 3, 1'b0, 32'hCAFE_0104, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
